// File: rtl/rtc_bus_bridge.sv
// PicoBlaze-to-RTC bridge: byte transfers on the multiplexed RTC bus, plus a shadow bank of RTC registers.
// Optional build macro AUTO_REFRESH_EN adds a periodic background sweep that refreshes the shadow bank.
module rtc_bus_bridge #(
    parameter int unsigned PHASE_CYC   = 4,
    parameter int unsigned NUM_SHADOW  = 10,
    parameter logic [7:0]  SHADOW_BASE = 8'h21,
    parameter logic [7:0]  PORT_ADDR   = 8'h01,
    parameter logic [7:0]  PORT_WDATA  = 8'h02,
    parameter logic [7:0]  PORT_STATUS = 8'h0F,
    parameter logic [7:0]  PORT_RDATA  = 8'h10,
    parameter int unsigned REFRESH_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              port_id,
    input  logic [7:0]              pb_out_port,
    input  logic                    write_strobe,
    input  logic                    read_strobe,
    output logic [7:0]              pb_in_port,
    inout  wire  [7:0]              dato,
    output logic                    reg_a_d,
    output logic                    reg_cs,
    output logic                    reg_rd,
    output logic                    reg_wr,
    output logic                    busy,
    output logic                    done_pulse,
    output logic [8*NUM_SHADOW-1:0] shadow_flat
);

    localparam int unsigned PH_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

    if (PHASE_CYC < 1 || NUM_SHADOW < 1 || NUM_SHADOW > 32 || REFRESH_CYC < 1) begin : g_bad_param
        $error("rtc_bus_bridge: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LATCH,
        ST_DATA,
        ST_RECOV
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        xfer_addr_q, xfer_addr_d;
    logic              xfer_wr_q, xfer_wr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              done_pulse_q, done_pulse_d;
    logic              busy_q, busy_d;
    logic [7:0]        pb_in_port_q, pb_in_port_d;
    logic              cs_q, cs_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ad_q, ad_d;
    logic              drv_q, drv_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        shadow_q [NUM_SHADOW];
    logic [7:0]        shadow_d [NUM_SHADOW];

    logic              phase_last_c;
    logic              finish_c;
    logic              wr_addr_c;
    logic              wr_data_c;
    logic              uc_req_c;
    logic              stat_rd_c;
    logic              sweep_bit_c;
    logic [7:0]        off_c;
    logic [7:0]        status_c;

    logic              done_set;
    logic              ovr_set;
    logic              launch;
    logic              uc_launch;
    logic              uc_wr;
    logic [7:0]        uc_byte;

`ifdef AUTO_REFRESH_EN
    localparam int unsigned IDX_W = (NUM_SHADOW > 1) ? $clog2(NUM_SHADOW) : 1;
    localparam int unsigned IC_W  = $clog2(REFRESH_CYC + 1);

    logic              sweep_q, sweep_d;
    logic [IDX_W-1:0]  sweep_idx_q, sweep_idx_d;
    logic [IC_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic              xfer_sweep_q, xfer_sweep_d;
    logic              pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    logic [7:0]        pend_byte_q, pend_byte_d;

    assign sweep_bit_c = sweep_q;
`else
    assign sweep_bit_c = 1'b0;
`endif

    assign phase_last_c = (phase_q == PH_W'(PHASE_CYC - 1));
    assign finish_c     = (state_q == ST_RECOV) && phase_last_c;
    assign wr_addr_c    = write_strobe && (port_id == PORT_ADDR);
    assign wr_data_c    = write_strobe && (port_id == PORT_WDATA);
    assign uc_req_c     = wr_addr_c || wr_data_c;
    assign stat_rd_c    = read_strobe && (port_id == PORT_STATUS);
    assign off_c        = xfer_addr_q - SHADOW_BASE;
    assign status_c     = {4'b0000, sweep_bit_c, overrun_q, busy_q, done_q};

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        addr_d       = addr_q;
        xfer_addr_d  = xfer_addr_q;
        xfer_wr_d    = xfer_wr_q;
        wdata_d      = wdata_q;
        byte_d       = byte_q;
        rdata_d      = rdata_q;
        shadow_d     = shadow_q;
        done_set     = 1'b0;
        ovr_set      = 1'b0;
        launch       = 1'b0;
        uc_launch    = 1'b0;
        uc_wr        = 1'b0;
        uc_byte      = 8'h00;
`ifdef AUTO_REFRESH_EN
        sweep_d      = sweep_q;
        sweep_idx_d  = sweep_idx_q;
        idle_cnt_d   = idle_cnt_q;
        xfer_sweep_d = xfer_sweep_q;
        pend_d       = pend_q;
        pend_wr_d    = pend_wr_q;
        pend_byte_d  = pend_byte_q;
`endif

        if (state_q != ST_IDLE) begin
            if (phase_last_c) begin
                phase_d = '0;
                case (state_q)
                    ST_ADDR:  state_d = ST_LATCH;
                    ST_LATCH: state_d = ST_DATA;
                    ST_DATA:  state_d = ST_RECOV;
                    default:  state_d = ST_IDLE;
                endcase
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end

        if ((state_q == ST_DATA) && phase_last_c && !xfer_wr_q) begin
            byte_d = dato;
        end

        // Only reads whose address falls in the window refresh the shadow bank
        if (finish_c && !xfer_wr_q) begin
            for (int unsigned i = 0; i < NUM_SHADOW; i++) begin
                if (off_c == 8'(i)) begin
                    shadow_d[i] = byte_q;
                end
            end
        end

`ifdef AUTO_REFRESH_EN
        if (finish_c && !xfer_sweep_q) begin
            done_set = 1'b1;
            if (!xfer_wr_q) begin
                rdata_d = byte_q;
            end
        end
        if (finish_c && xfer_sweep_q) begin
            if (sweep_idx_q == IDX_W'(NUM_SHADOW - 1)) begin
                sweep_d = 1'b0;
            end else begin
                sweep_idx_d = sweep_idx_q + IDX_W'(1);
            end
        end

        // A parked uC request goes first, then a fresh one, then the sweep
        if (state_q == ST_IDLE) begin
            if (pend_q) begin
                uc_launch = 1'b1;
                uc_wr     = pend_wr_q;
                uc_byte   = pend_byte_q;
                pend_d    = uc_req_c;
                if (uc_req_c) begin
                    pend_wr_d   = wr_data_c;
                    pend_byte_d = pb_out_port;
                end
            end else if (uc_req_c) begin
                uc_launch = 1'b1;
                uc_wr     = wr_data_c;
                uc_byte   = pb_out_port;
            end else if (sweep_q || (idle_cnt_q == IC_W'(REFRESH_CYC - 1))) begin
                launch       = 1'b1;
                xfer_wr_d    = 1'b0;
                xfer_sweep_d = 1'b1;
                if (sweep_q) begin
                    xfer_addr_d = SHADOW_BASE + 8'(sweep_idx_q);
                end else begin
                    sweep_d     = 1'b1;
                    sweep_idx_d = '0;
                    xfer_addr_d = SHADOW_BASE;
                end
            end else begin
                idle_cnt_d = idle_cnt_q + IC_W'(1);
            end
        end else if (uc_req_c) begin
            if (sweep_q && !pend_q) begin
                pend_d      = 1'b1;
                pend_wr_d   = wr_data_c;
                pend_byte_d = pb_out_port;
            end else begin
                ovr_set = 1'b1;
            end
        end

        if (uc_launch) begin
            xfer_sweep_d = 1'b0;
        end
        if ((state_q != ST_IDLE) || launch || uc_launch) begin
            idle_cnt_d = '0;
        end
`else
        if (finish_c) begin
            done_set = 1'b1;
            if (!xfer_wr_q) begin
                rdata_d = byte_q;
            end
        end

        if (uc_req_c) begin
            if (state_q == ST_IDLE) begin
                uc_launch = 1'b1;
                uc_wr     = wr_data_c;
                uc_byte   = pb_out_port;
            end else begin
                ovr_set = 1'b1;
            end
        end
`endif

        // A read latches the address register; a write reuses the last one
        if (uc_launch) begin
            launch    = 1'b1;
            xfer_wr_d = uc_wr;
            if (uc_wr) begin
                xfer_addr_d = addr_q;
                wdata_d     = uc_byte;
            end else begin
                addr_d      = uc_byte;
                xfer_addr_d = uc_byte;
            end
        end

        if (launch) begin
            state_d = ST_ADDR;
            phase_d = '0;
        end

        // Bus pins follow the state being entered so they stay aligned with it
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        ad_d   = 1'b1;
        drv_d  = 1'b0;
        dout_d = 8'h00;
        case (state_d)
            ST_ADDR: begin
                cs_d   = 1'b0;
                ad_d   = 1'b0;
                wr_d   = 1'b0;
                drv_d  = 1'b1;
                dout_d = xfer_addr_d;
            end
            ST_LATCH: begin
                cs_d   = 1'b0;
                ad_d   = 1'b0;
                drv_d  = 1'b1;
                dout_d = xfer_addr_d;
            end
            ST_DATA: begin
                cs_d = 1'b0;
                if (xfer_wr_d) begin
                    wr_d   = 1'b0;
                    drv_d  = 1'b1;
                    dout_d = wdata_d;
                end else begin
                    rd_d = 1'b0;
                end
            end
            default: ;
        endcase

        busy_d       = (state_d != ST_IDLE);
        done_pulse_d = done_set;
        done_d       = done_set || (done_q && !stat_rd_c);
        overrun_d    = ovr_set || (overrun_q && !stat_rd_c);

        if (port_id == PORT_STATUS) begin
            pb_in_port_d = status_c;
        end else if (port_id == PORT_RDATA) begin
            pb_in_port_d = rdata_q;
        end else begin
            pb_in_port_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            addr_q       <= 8'h00;
            xfer_addr_q  <= 8'h00;
            xfer_wr_q    <= 1'b0;
            wdata_q      <= 8'h00;
            byte_q       <= 8'h00;
            rdata_q      <= 8'h00;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            done_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            pb_in_port_q <= 8'h00;
            cs_q         <= 1'b1;
            rd_q         <= 1'b1;
            wr_q         <= 1'b1;
            ad_q         <= 1'b1;
            drv_q        <= 1'b0;
            dout_q       <= 8'h00;
            shadow_q     <= '{default: 8'h00};
`ifdef AUTO_REFRESH_EN
            sweep_q      <= 1'b0;
            sweep_idx_q  <= '0;
            idle_cnt_q   <= '0;
            xfer_sweep_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_byte_q  <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            addr_q       <= addr_d;
            xfer_addr_q  <= xfer_addr_d;
            xfer_wr_q    <= xfer_wr_d;
            wdata_q      <= wdata_d;
            byte_q       <= byte_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            done_pulse_q <= done_pulse_d;
            busy_q       <= busy_d;
            pb_in_port_q <= pb_in_port_d;
            cs_q         <= cs_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            ad_q         <= ad_d;
            drv_q        <= drv_d;
            dout_q       <= dout_d;
            shadow_q     <= shadow_d;
`ifdef AUTO_REFRESH_EN
            sweep_q      <= sweep_d;
            sweep_idx_q  <= sweep_idx_d;
            idle_cnt_q   <= idle_cnt_d;
            xfer_sweep_q <= xfer_sweep_d;
            pend_q       <= pend_d;
            pend_wr_q    <= pend_wr_d;
            pend_byte_q  <= pend_byte_d;
`endif
        end
    end

    assign dato       = drv_q ? dout_q : 8'hzz;
    assign reg_cs     = cs_q;
    assign reg_rd     = rd_q;
    assign reg_wr     = wr_q;
    assign reg_a_d    = ad_q;
    assign busy       = busy_q;
    assign done_pulse = done_pulse_q;
    assign pb_in_port = pb_in_port_q;

    for (genvar g = 0; g < NUM_SHADOW; g++) begin : g_flat
        assign shadow_flat[8*g +: 8] = shadow_q[g];
    end

endmodule

// File: tb/tb_rtc_bus_bridge.sv
// Scoreboard bench for rtc_bus_bridge with a behavioural RTC on the multiplexed bus.
module tb_rtc_bus_bridge;

    localparam int unsigned PHASE_CYC   = 4;
    localparam int unsigned NUM_SHADOW  = 10;
    localparam logic [7:0]  SHADOW_BASE = 8'h21;
    localparam logic [7:0]  PORT_ADDR   = 8'h01;
    localparam logic [7:0]  PORT_WDATA  = 8'h02;
    localparam logic [7:0]  PORT_STATUS = 8'h0F;
    localparam logic [7:0]  PORT_RDATA  = 8'h10;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [7:0]              port_id = 8'h00;
    logic [7:0]              pb_out_port = 8'h00;
    logic                    write_strobe = 1'b0;
    logic                    read_strobe = 1'b0;
    logic [7:0]              pb_in_port;
    wire  [7:0]              dato;
    logic                    reg_a_d;
    logic                    reg_cs;
    logic                    reg_rd;
    logic                    reg_wr;
    logic                    busy;
    logic                    done_pulse;
    logic [8*NUM_SHADOW-1:0] shadow_flat;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  rtc_mem [256];
    logic [7:0]  rtc_addr = 8'h00;
    logic [7:0]  rtc_q;
    logic        in_wdata = 1'b0;
    logic [7:0]  sh_model [NUM_SHADOW];
    logic [7:0]  exp_rd_q [$];
    logic [15:0] exp_wr_q [$];
    logic [15:0] obs_wr_q [$];

    rtc_bus_bridge #(
        .PHASE_CYC   (PHASE_CYC),
        .NUM_SHADOW  (NUM_SHADOW),
        .SHADOW_BASE (SHADOW_BASE),
        .PORT_ADDR   (PORT_ADDR),
        .PORT_WDATA  (PORT_WDATA),
        .PORT_STATUS (PORT_STATUS),
        .PORT_RDATA  (PORT_RDATA),
        .REFRESH_CYC (1000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .pb_out_port  (pb_out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .pb_in_port   (pb_in_port),
        .dato         (dato),
        .reg_a_d      (reg_a_d),
        .reg_cs       (reg_cs),
        .reg_rd       (reg_rd),
        .reg_wr       (reg_wr),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .shadow_flat  (shadow_flat)
    );

    always #5 clk = ~clk;

    // RTC device model: returns memory contents while selected and read-strobed
    assign rtc_q = rtc_mem[rtc_addr];
    assign dato  = (!reg_cs && !reg_rd) ? rtc_q : 8'hzz;

    always @(negedge clk) begin
        if (!reg_cs && !reg_a_d && !reg_wr) rtc_addr = dato;
        if (!reg_cs && reg_a_d && !reg_wr) begin
            if (!in_wdata) begin
                rtc_mem[rtc_addr] = dato;
                obs_wr_q.push_back({rtc_addr, dato});
            end
            in_wdata = 1'b1;
        end else begin
            in_wdata = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*NUM_SHADOW-1:0] model_flat();
        logic [8*NUM_SHADOW-1:0] f;
        f = '0;
        for (int i = 0; i < int'(NUM_SHADOW); i++) f[8*i +: 8] = sh_model[i];
        return f;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pb_write(input logic [7:0] p, input logic [7:0] d);
        port_id      = p;
        pb_out_port  = d;
        write_strobe = 1'b1;
        cycle();
        write_strobe = 1'b0;
    endtask

    task automatic pb_read(input logic [7:0] p, output logic [7:0] d);
        port_id     = p;
        read_strobe = 1'b1;
        cycle();
        read_strobe = 1'b0;
        d = pb_in_port;
    endtask

    task automatic wait_done(output int busy_cyc, output int cs_cyc);
        logic seen;
        seen     = 1'b0;
        busy_cyc = 0;
        cs_cyc   = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (done_pulse) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cyc++;
                if (!reg_cs) cs_cyc++;
                cycle();
            end
        end
        if (!seen) check("done_timeout", 128'(0), 128'(1));
    endtask

    task automatic model_read(input logic [7:0] a);
        logic [7:0] off;
        off = a - SHADOW_BASE;
        for (int i = 0; i < int'(NUM_SHADOW); i++) begin
            if (off == 8'(i)) sh_model[i] = rtc_mem[a];
        end
    endtask

    task automatic pop_rdata(input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        pb_read(PORT_RDATA, got);
        exp = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 8'hxx;
        check(tag, 128'(got), 128'(exp));
    endtask

    task automatic do_read(input logic [7:0] a);
        int bc;
        int cc;
        pb_write(PORT_ADDR, a);
        exp_rd_q.push_back(rtc_mem[a]);
        model_read(a);
        wait_done(bc, cc);
        check("busy_cycles", 128'(bc), 128'(4 * PHASE_CYC));
        check("cs_low_cycles", 128'(cc), 128'(3 * PHASE_CYC));
        check("rtc_addr_seen", 128'(rtc_addr), 128'(a));
        cycle();
        check("done_pulse_width", 128'(done_pulse), 128'(0));
        pop_rdata("rdata");
        check("shadow", 128'(shadow_flat), 128'(model_flat()));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] st;
        logic [15:0] ow;
        logic [7:0] oow_addrs [4];
        int bc;
        int cc;
        int dp;

        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < int'(NUM_SHADOW); i++) sh_model[i] = 8'h00;
        rtc_mem[8'h21] = 8'h59;
        rtc_mem[8'h22] = 8'h33;
        rtc_mem[8'h23] = 8'h77;
        rtc_mem[8'h24] = 8'hAB;
        rtc_mem[8'h25] = 8'h9C;
        rtc_mem[8'h2A] = 8'h5A;
        rtc_mem[8'h2B] = 8'hB2;
        rtc_mem[8'h20] = 8'hC0;
        rtc_mem[8'h10] = 8'h3C;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle();

        check("reset_bus_pins", 128'({reg_cs, reg_rd, reg_wr, reg_a_d}), 128'(4'hF));
        check("reset_busy_done", 128'({busy, done_pulse}), 128'(2'b00));
        check("reset_in_port", 128'(pb_in_port), 128'(0));
        check("reset_shadow", 128'(shadow_flat), 128'(0));
        check("reset_dato_released", 128'(dut.drv_q), 128'(0));

        // Read inside the window
        do_read(8'h21);
        pb_read(PORT_STATUS, st);
        check("status_after_read", 128'(st), 128'(8'h01));
        pb_read(8'h55, st);
        check("unmapped_port", 128'(st), 128'(8'h00));

        // Read then write at the same address
        do_read(8'h22);
        pb_write(PORT_WDATA, 8'h45);
        exp_wr_q.push_back({8'h22, 8'h45});
        wait_done(bc, cc);
        check("write_busy_cycles", 128'(bc), 128'(4 * PHASE_CYC));
        check("write_seen_count", 128'(obs_wr_q.size()), 128'(1));
        ow = (obs_wr_q.size() > 0) ? obs_wr_q.pop_front() : 16'hxxxx;
        check("write_addr_data", 128'(ow), 128'(exp_wr_q.pop_front()));
        check("write_shadow", 128'(shadow_flat), 128'(model_flat()));
        exp_rd_q.push_back(8'h33);
        pop_rdata("rdata_after_write");

        // Overrun: second start three cycles into the first transfer
        pb_read(PORT_STATUS, st);
        pb_write(PORT_ADDR, 8'h23);
        exp_rd_q.push_back(rtc_mem[8'h23]);
        model_read(8'h23);
        cycle();
        cycle();
        pb_write(PORT_ADDR, 8'h24);
        wait_done(bc, cc);
        check("overrun_addr", 128'(rtc_addr), 128'(8'h23));
        bc = 0;
        dp = 0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (busy) bc++;
            if (done_pulse) dp++;
        end
        check("overrun_single_xfer", 128'({8'(bc), 8'(dp)}), 128'(0));
        pop_rdata("overrun_rdata");
        check("overrun_shadow", 128'(shadow_flat), 128'(model_flat()));
        pb_read(PORT_STATUS, st);
        check("overrun_status", 128'(st), 128'(8'h05));
        pb_read(PORT_STATUS, st);
        check("overrun_status_cleared", 128'(st), 128'(8'h00));

        // Status read in the very cycle that done is set
        pb_write(PORT_ADDR, 8'h25);
        exp_rd_q.push_back(rtc_mem[8'h25]);
        model_read(8'h25);
        repeat (4 * PHASE_CYC - 1) cycle();
        pb_read(PORT_STATUS, st);
        check("collision_status_pre", 128'(st), 128'(8'h02));
        check("collision_done_pulse", 128'(done_pulse), 128'(1));
        pb_read(PORT_STATUS, st);
        check("collision_done_kept", 128'(st), 128'(8'h01));
        pb_read(PORT_STATUS, st);
        check("collision_cleared", 128'(st), 128'(8'h00));
        pop_rdata("collision_rdata");

        // Reset in the middle of the data phase
        pb_write(PORT_ADDR, 8'h24);
        repeat (2 * PHASE_CYC + 1) cycle();
        check("mid_data_rd_low", 128'({reg_cs, reg_rd, reg_a_d}), 128'(3'b001));
        reset = 1'b0;
        #1;
        exp_rd_q.push_back(8'h00);
        for (int i = 0; i < int'(NUM_SHADOW); i++) sh_model[i] = 8'h00;
        check("reset_mid_pins", 128'({reg_cs, reg_rd, reg_wr, reg_a_d}), 128'(4'hF));
        check("reset_mid_busy", 128'(busy), 128'(0));
        check("reset_mid_dato", 128'(dut.drv_q), 128'(0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        dp = 0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (done_pulse || busy) dp++;
        end
        check("reset_mid_no_finish", 128'(dp), 128'(0));
        pop_rdata("reset_mid_rdata");
        check("reset_mid_shadow", 128'(shadow_flat), 128'(model_flat()));

        // Window edges and out-of-window addresses
        oow_addrs[0] = 8'h2A;
        oow_addrs[1] = 8'h2B;
        oow_addrs[2] = 8'h20;
        oow_addrs[3] = 8'h10;
        for (int i = 0; i < 4; i++) do_read(oow_addrs[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
